// File: rtl/stat_controller.sv
// stat_controller: STAT (FF41) / LYC (FF45) registers, LY=LYC flag,
// edge-blocked STAT interrupt and VBlank interrupt as one-cycle pulses.
module stat_controller #(
    parameter logic [15:0] STAT_ADDR = 16'hFF41,
    parameter logic [15:0] LYC_ADDR  = 16'hFF45
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slow_clk_en,
    input  logic        ppu_enable,
    input  logic [7:0]  ly,
    input  logic [1:0]  mode,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic [7:0]  cpu_rdata,
    output logic        stat_irq,
    output logic        vblank_irq
);
    logic [3:0] stat_en;
    logic [7:0] lyc;
    logic       coinc;
    logic       stat_line_prev;
    logic [1:0] mode_prev;
    logic       stat_line;
    logic       stat_hit;
    logic       lyc_hit;

    assign stat_hit = cpu_addr == STAT_ADDR;
    assign lyc_hit  = cpu_addr == LYC_ADDR;

    always_comb begin
        stat_line = ppu_enable & ((stat_en[0] & (mode == 2'd0)) |
                                  (stat_en[1] & (mode == 2'd1)) |
                                  (stat_en[2] & (mode == 2'd2)) |
                                  (stat_en[3] & coinc));
        cpu_rdata = stat_hit ? {1'b1, stat_en, coinc, mode} : lyc_hit ? lyc : 8'h00;
    end

    // Line and coinc are evaluated from pre-write register values, so a write
    // landing on a tick only takes effect at the following tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_en        <= 4'd0;
            lyc            <= 8'd0;
            coinc          <= 1'b0;
            stat_line_prev <= 1'b0;
            mode_prev      <= 2'd0;
            stat_irq       <= 1'b0;
            vblank_irq     <= 1'b0;
        end else begin
            stat_irq   <= 1'b0;
            vblank_irq <= 1'b0;
            if (cpu_we && stat_hit)
                stat_en <= cpu_wdata[6:3];
            if (cpu_we && lyc_hit)
                lyc <= cpu_wdata;
            if (slow_clk_en)
                coinc <= ly == lyc;
            if (!ppu_enable) begin
                stat_line_prev <= 1'b0;
                mode_prev      <= 2'd0;
            end else if (slow_clk_en) begin
                stat_irq       <= stat_line & ~stat_line_prev;
                stat_line_prev <= stat_line;
                vblank_irq     <= (mode == 2'd1) && (mode_prev != 2'd1);
                mode_prev      <= mode;
            end
        end
    end
endmodule
